// File: rtl/ebus_phi_rx_if.sv
// Bus-side timing signals seen by the PHI/reset receive monitor.
// The slave modport is the monitor; the master modport drives PHI and bus reset.
interface ebus_phi_rx_if #(
  parameter int CNT_W = 8
);
  logic             ebus_phi;
  logic             ebus_reset_n;
  logic             phi_rise;
  logic             phi_fall;
  logic [CNT_W-1:0] phi_period;
  logic             phi_valid;
  logic             phi_stalled;
  logic             turbo_detected;
  logic             bus_reset;
  logic             reset_done;
  logic [7:0]       reset_len;

  modport master (
    output ebus_phi, ebus_reset_n,
    input  phi_rise, phi_fall, phi_period, phi_valid, phi_stalled,
           turbo_detected, bus_reset, reset_done, reset_len
  );

  modport slave (
    input  ebus_phi, ebus_reset_n,
    output phi_rise, phi_fall, phi_period, phi_valid, phi_stalled,
           turbo_detected, bus_reset, reset_done, reset_len
  );
endinterface

// File: rtl/ebus_phi_rx.sv
// Tracks external bus PHI and bus reset in the sysclk domain: edge strobes,
// PHI period/lock/stall/turbo status, glitch-filtered bus reset and its length.
module ebus_phi_rx #(
  parameter int CNT_W         = 8,
  parameter int STALL_CYCLES  = 64,
  parameter int TURBO_MAX     = 5,
  parameter int FILTER_CYCLES = 4
) (
  input  logic         sysclk,
  input  logic         reset_n,
  ebus_phi_rx_if.slave bus
);

  localparam int FW = $clog2(FILTER_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] STALL_TH = CNT_W'(STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] TURBO_TH = CNT_W'(TURBO_MAX);
  localparam logic [FW-1:0]    FLT_TH   = FW'(FILTER_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACQ, LOCK, STALL} phi_state_t;

  phi_state_t       r_state;
  phi_state_t       w_state_nxt;

  logic             r_phi_s1, r_phi_s2, r_phi_d;
  logic             r_rst_s1, r_rst_s2;
  logic             w_rise, w_fall;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_meas;
  logic             w_stall_hit;

  logic             r_phi_rise, r_phi_fall;
  logic [CNT_W-1:0] r_period, w_period_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_stalled, w_stalled_nxt;
  logic             r_turbo, w_turbo_nxt;

  logic [FW-1:0]    r_fcnt;
  logic             r_bus_reset;
  logic             w_disagree, w_toggle, w_assert, w_deassert;
  logic [7:0]       r_rcnt, w_rcnt_nxt;
  logic [7:0]       r_reset_len;
  logic             r_reset_done;

  // PHI resets to low and bus reset line to released, so no edge or reset is seen out of reset
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      r_phi_s1 <= 1'b0;
      r_phi_s2 <= 1'b0;
      r_phi_d  <= 1'b0;
      r_rst_s1 <= 1'b1;
      r_rst_s2 <= 1'b1;
    end else begin
      r_phi_s1 <= bus.ebus_phi;
      r_phi_s2 <= r_phi_s1;
      r_phi_d  <= r_phi_s2;
      r_rst_s1 <= bus.ebus_reset_n;
      r_rst_s2 <= r_rst_s1;
    end
  end

  assign w_rise      = r_phi_s2 & ~r_phi_d;
  assign w_fall      = ~r_phi_s2 & r_phi_d;
  assign w_meas      = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + 1'b1;
  assign w_stall_hit = (r_cnt == STALL_TH);

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (w_rise) begin
      r_cnt <= '0;
    end else if (r_cnt != CNT_MAX) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A rise on the threshold cycle takes priority over declaring a stall
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_rise) w_state_nxt = ACQ;
      ACQ:     if (w_rise) w_state_nxt = LOCK;
               else if (w_stall_hit) w_state_nxt = STALL;
      LOCK:    if (!w_rise && w_stall_hit) w_state_nxt = STALL;
      STALL:   if (w_rise) w_state_nxt = ACQ;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_period_nxt = r_period;
    if (w_state_nxt == STALL) begin
      w_period_nxt = '0;
    end else if (w_rise && (r_state == ACQ || r_state == LOCK)) begin
      w_period_nxt = w_meas;
    end
    w_valid_nxt   = (w_state_nxt == LOCK);
    w_stalled_nxt = (w_state_nxt == STALL);
    w_turbo_nxt   = w_valid_nxt && (w_period_nxt <= TURBO_TH);
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      r_phi_rise <= 1'b0;
      r_phi_fall <= 1'b0;
      r_period   <= '0;
      r_valid    <= 1'b0;
      r_stalled  <= 1'b0;
      r_turbo    <= 1'b0;
    end else begin
      r_phi_rise <= w_rise;
      r_phi_fall <= w_fall;
      r_period   <= w_period_nxt;
      r_valid    <= w_valid_nxt;
      r_stalled  <= w_stalled_nxt;
      r_turbo    <= w_turbo_nxt;
    end
  end

  // Synced line low while bus_reset low (or high while high) is a disagreeing sample
  assign w_disagree = (r_rst_s2 == r_bus_reset);
  assign w_toggle   = w_disagree && (r_fcnt == FLT_TH);
  assign w_assert   = w_toggle & ~r_bus_reset;
  assign w_deassert = w_toggle & r_bus_reset;

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      r_fcnt      <= '0;
      r_bus_reset <= 1'b0;
    end else if (!w_disagree || w_toggle) begin
      r_fcnt      <= '0;
      r_bus_reset <= r_bus_reset ^ w_toggle;
    end else begin
      r_fcnt      <= r_fcnt + 1'b1;
    end
  end

  assign w_rcnt_nxt = (r_bus_reset && w_rise && r_rcnt != 8'hFF) ? r_rcnt + 8'd1 : r_rcnt;

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      r_rcnt       <= '0;
      r_reset_len  <= '0;
      r_reset_done <= 1'b0;
    end else begin
      r_rcnt       <= w_assert ? 8'd0 : w_rcnt_nxt;
      r_reset_done <= w_deassert;
      if (w_deassert) begin
        r_reset_len <= w_rcnt_nxt;
      end
    end
  end

  assign bus.phi_rise       = r_phi_rise;
  assign bus.phi_fall       = r_phi_fall;
  assign bus.phi_period     = r_period;
  assign bus.phi_valid      = r_valid;
  assign bus.phi_stalled    = r_stalled;
  assign bus.turbo_detected = r_turbo;
  assign bus.bus_reset      = r_bus_reset;
  assign bus.reset_done     = r_reset_done;
  assign bus.reset_len      = r_reset_len;

endmodule

// File: tb/tb_ebus_phi_rx.sv
// Scoreboard bench for ebus_phi_rx: stimulus queues expected PHI-rise status and
// reset_done lengths; a negedge monitor pops and compares when the DUT strobes.
module tb_ebus_phi_rx;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  ebus_phi_rx_if #(.CNT_W(8)) ifc ();

  ebus_phi_rx #(
    .CNT_W(8), .STALL_CYCLES(64), .TURBO_MAX(5), .FILTER_CYCLES(4)
  ) dut (
    .sysclk (clk),
    .reset_n(rstN),
    .bus    (ifc.slave)
  );

  typedef struct packed {
    logic [7:0] period;
    logic       valid;
    logic       turbo;
  } rise_exp_t;

  rise_exp_t  riseQ[$];
  int         latQ[$];
  logic [7:0] doneQ[$];
  rise_exp_t  riseE;
  logic [7:0] doneE;
  int testsRun  = 0;
  int failCount = 0;
  int cycleCnt  = 0;
  logic glitchSeen;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic pushRise(input logic [7:0] period, input logic valid, input logic turbo, input int n);
    rise_exp_t e;
    e.period = period;
    e.valid  = valid;
    e.turbo  = turbo;
    for (int i = 0; i < n; i++) riseQ.push_back(e);
  endtask

  task automatic setPhi(input logic v);
    if (v && !ifc.ebus_phi) latQ.push_back(cycleCnt);
    ifc.ebus_phi = v;
  endtask

  // Each PHI period starts low for 'half' cycles then high for 'half' cycles
  task automatic applyStimulus(input int half, input int n);
    for (int i = 0; i < n; i++) begin
      setPhi(1'b0);
      repeat (half) @(negedge clk);
      setPhi(1'b1);
      repeat (half) @(negedge clk);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_phi_rise"},    32'(ifc.phi_rise), 0);
    checkOutput({tag, "_phi_fall"},    32'(ifc.phi_fall), 0);
    checkOutput({tag, "_phi_period"},  32'(ifc.phi_period), 0);
    checkOutput({tag, "_phi_valid"},   32'(ifc.phi_valid), 0);
    checkOutput({tag, "_phi_stalled"}, 32'(ifc.phi_stalled), 0);
    checkOutput({tag, "_turbo"},       32'(ifc.turbo_detected), 0);
    checkOutput({tag, "_bus_reset"},   32'(ifc.bus_reset), 0);
    checkOutput({tag, "_reset_done"},  32'(ifc.reset_done), 0);
    checkOutput({tag, "_reset_len"},   32'(ifc.reset_len), 0);
  endtask

  always @(negedge clk) begin
    if (ifc.phi_rise === 1'b1) begin
      checkOutput("rise_fall_exclusive", 32'(ifc.phi_fall), 0);
      if (riseQ.size() == 0) begin
        testsRun++;
        failCount++;
        $display("[TB] FAIL unexpected_phi_rise: got rise at cycle %0d, expected none", cycleCnt);
      end else begin
        riseE = riseQ.pop_front();
        checkOutput("phi_period",  32'(ifc.phi_period), 32'(riseE.period));
        checkOutput("phi_valid",   32'(ifc.phi_valid), 32'(riseE.valid));
        checkOutput("turbo",       32'(ifc.turbo_detected), 32'(riseE.turbo));
        checkOutput("phi_stalled", 32'(ifc.phi_stalled), 0);
      end
      if (latQ.size() != 0) checkOutput("rise_latency", 32'(cycleCnt - latQ.pop_front()), 3);
    end
    if (ifc.reset_done === 1'b1) begin
      if (doneQ.size() == 0) begin
        testsRun++;
        failCount++;
        $display("[TB] FAIL unexpected_reset_done: got pulse at cycle %0d, expected none", cycleCnt);
      end else begin
        doneE = doneQ.pop_front();
        checkOutput("reset_len", 32'(ifc.reset_len), 32'(doneE));
        checkOutput("bus_reset_at_done", 32'(ifc.bus_reset), 0);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    ifc.ebus_phi     = 1'b0;
    ifc.ebus_reset_n = 1'b1;
    rstN             = 1'b0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rstN = 1'b1;
    @(negedge clk);

    // Normal PHI: acquire on first rise, lock at period 8 on the second
    pushRise(8'd0, 1'b0, 1'b0, 1);
    pushRise(8'd8, 1'b1, 1'b0, 5);
    applyStimulus(4, 6);

    // Switch to turbo: one 6-cycle transitional period, then 4
    pushRise(8'd6, 1'b1, 1'b0, 1);
    pushRise(8'd4, 1'b1, 1'b1, 3);
    applyStimulus(2, 4);

    // PHI held high -> stall, then recover through ACQ into LOCK
    repeat (70) @(negedge clk);
    checkOutput("stall_stalled", 32'(ifc.phi_stalled), 1);
    checkOutput("stall_valid",   32'(ifc.phi_valid), 0);
    checkOutput("stall_period",  32'(ifc.phi_period), 0);
    checkOutput("stall_turbo",   32'(ifc.turbo_detected), 0);
    pushRise(8'd0, 1'b0, 1'b0, 1);
    pushRise(8'd8, 1'b1, 1'b0, 3);
    applyStimulus(4, 4);

    // Rise exactly STALL_CYCLES after the previous one: stays locked
    repeat (28) @(negedge clk);
    setPhi(1'b0);
    repeat (32) @(negedge clk);
    pushRise(8'd64, 1'b1, 1'b0, 1);
    setPhi(1'b1);
    repeat (4) @(negedge clk);
    pushRise(8'd8, 1'b1, 1'b0, 2);
    applyStimulus(4, 2);

    // Three-sample bus reset glitch must be filtered out
    pushRise(8'd8, 1'b1, 1'b0, 2);
    glitchSeen = 1'b0;
    fork
      applyStimulus(4, 2);
      begin
        ifc.ebus_reset_n = 1'b0;
        repeat (3) @(negedge clk);
        ifc.ebus_reset_n = 1'b1;
        repeat (13) begin
          @(negedge clk);
          if (ifc.bus_reset !== 1'b0) glitchSeen = 1'b1;
        end
      end
    join
    checkOutput("glitch_bus_reset", 32'(glitchSeen), 0);

    // 60-cycle bus reset with period-8 PHI: eight rises land inside the window
    pushRise(8'd8, 1'b1, 1'b0, 9);
    doneQ.push_back(8'd8);
    fork
      applyStimulus(4, 9);
      begin
        ifc.ebus_reset_n = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("assert_before_6", 32'(ifc.bus_reset), 0);
        @(negedge clk);
        checkOutput("assert_at_6", 32'(ifc.bus_reset), 1);
        repeat (54) @(negedge clk);
        ifc.ebus_reset_n = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("deassert_before_6", 32'(ifc.bus_reset), 1);
        @(negedge clk);
        checkOutput("deassert_at_6", 32'(ifc.bus_reset), 0);
      end
    join

    // Async reset while locked and in bus reset
    pushRise(8'd8, 1'b1, 1'b0, 2);
    ifc.ebus_reset_n = 1'b0;
    applyStimulus(4, 2);
    checkOutput("pre_pulse_bus_reset", 32'(ifc.bus_reset), 1);
    checkOutput("pre_pulse_valid",     32'(ifc.phi_valid), 1);
    setPhi(1'b0);
    rstN = 1'b0;
    #1;
    checkAllZero("async");
    @(negedge clk);
    rstN = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("reassert_before_6", 32'(ifc.bus_reset), 0);
    @(negedge clk);
    checkOutput("reassert_at_6", 32'(ifc.bus_reset), 1);
    pushRise(8'd0, 1'b0, 1'b0, 1);
    pushRise(8'd8, 1'b1, 1'b0, 2);
    doneQ.push_back(8'd3);
    applyStimulus(4, 3);
    ifc.ebus_reset_n = 1'b1;

    for (int i = 0; i < 50; i++) begin
      if (riseQ.size() == 0 && doneQ.size() == 0) break;
      @(negedge clk);
    end
    checkOutput("rise_queue_drained", 32'(riseQ.size()), 0);
    checkOutput("done_queue_drained", 32'(doneQ.size()), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
